// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the ADC SPI sampler.
package adc_pkg;

    localparam int ADC_BITS = 24;

    // SPI mode 0: CPOL=0, CPHA=0, so SCLK idles low and data is captured on the high half.
    localparam logic [1:0] SPI_MODE  = 2'd0;
    localparam logic       SCLK_IDLE = SPI_MODE[1];

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        ACCUM
    } state_t;

endpackage

// File: rtl/adc_spi_sampler_if.sv
// ADC pin and result bundle; master is the sampler, slave is the converter/consumer side.
interface adc_spi_sampler_if;

    logic                         adc_drdy_n;
    logic                         adc_miso;
    logic                         adc_cs_n;
    logic                         adc_sclk;
    logic [adc_pkg::ADC_BITS-1:0] adc_value;
    logic                         adc_valid;
    logic                         adc_timeout;

    modport master (
        input  adc_drdy_n, adc_miso,
        output adc_cs_n, adc_sclk, adc_value, adc_valid, adc_timeout
    );

    modport slave (
        output adc_drdy_n, adc_miso,
        input  adc_cs_n, adc_sclk, adc_value, adc_valid, adc_timeout
    );

endinterface

// File: rtl/adc_spi_shift.sv
// SPI read engine: CS setup, 24 SCLK periods MSB-first, CS hold; done pulses with data.
// Latency from i_start to o_done is 50*CLK_DIV+1 clocks; i_start is ignored while busy.
module adc_spi_shift
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic                i_miso,
    output logic                o_cs_n,
    output logic                o_sclk,
    output logic                o_done,
    output logic [ADC_BITS-1:0] o_data
);

    localparam int DIV_W = $clog2(CLK_DIV);

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [4:0]          r_bit;
    logic [ADC_BITS-1:0] r_shift;
    logic                r_cs_n;
    logic                r_sclk;
    logic                r_done;
    logic                w_div_end;

    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= SCLK_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cs_n  <= 1'b0;
                        r_div   <= '0;
                        r_state <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_div_end) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        // Capture on the last clock of the high half, just before SCLK falls.
                        if (r_sclk) begin
                            r_shift <= {r_shift[ADC_BITS-2:0], i_miso};
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == 5'(ADC_BITS - 1)) begin
                                r_state <= CS_HOLD;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cs_n = r_cs_n;
    assign o_sclk = r_sclk;
    assign o_done = r_done;
    assign o_data = r_shift;

endmodule

// File: rtl/adc_spi_sampler.sv
// Syncs DRDY/MISO, arms on DRDY high, reads one frame per DRDY fall, averages 2^AVG_LOG2 frames.
// adc_valid pulses one clock after the final ACCUM; sticky adc_timeout after DRDY_TIMEOUT idle clocks.
module adc_spi_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = 50,
    parameter int AVG_LOG2     = 3,
    parameter int DRDY_TIMEOUT = 10000000
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    adc_spi_sampler_if.master bus
);

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TO_W  = $clog2(DRDY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

    logic                r_drdy_s1, r_drdy_s2;
    logic                r_miso_s1, r_miso_s2;
    state_t              r_state;
    logic                r_armed;
    logic                r_start;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [ADC_BITS-1:0] r_value;
    logic                r_valid;
    logic                r_timeout;

    logic                w_cs_n;
    logic                w_sclk;
    logic                w_done;
    logic [ADC_BITS-1:0] w_data;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [CNT_W-1:0]    w_cnt_next;

    assign w_acc_sum  = r_acc + ACC_W'(w_data);
    assign w_cnt_next = r_cnt + CNT_W'(1);

    adc_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk     (CLK100MHZ),
        .reset   (reset),
        .i_start (r_start),
        .i_miso  (r_miso_s2),
        .o_cs_n  (w_cs_n),
        .o_sclk  (w_sclk),
        .o_done  (w_done),
        .o_data  (w_data)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_drdy_s1 <= 1'b1;
            r_drdy_s2 <= 1'b1;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
            r_state   <= IDLE;
            r_armed   <= 1'b1;
            r_start   <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_to_cnt  <= '0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_drdy_s1 <= bus.adc_drdy_n;
            r_drdy_s2 <= r_drdy_s1;
            r_miso_s1 <= bus.adc_miso;
            r_miso_s2 <= r_miso_s1;
            r_start   <= 1'b0;
            r_valid   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // armed blocks a second read while DRDY is still low from the same conversion
                    if (r_drdy_s2) begin
                        r_armed <= 1'b1;
                    end
                    if (!r_drdy_s2 && r_armed) begin
                        r_armed  <= 1'b0;
                        r_start  <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= SHIFT;
                    end else if (r_to_cnt == TO_W'(DRDY_TIMEOUT - 1)) begin
                        r_to_cnt  <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_done) begin
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_state <= IDLE;
                    if (w_cnt_next == CNT_FULL) begin
                        r_value   <= w_acc_sum[ACC_W-1:AVG_LOG2];
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b0;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_acc <= w_acc_sum;
                        r_cnt <= w_cnt_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.adc_cs_n    = w_cs_n;
    assign bus.adc_sclk    = w_sclk;
    assign bus.adc_value   = r_value;
    assign bus.adc_valid   = r_valid;
    assign bus.adc_timeout = r_timeout;

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Upstream feeder for the battery/percent display stage.
- Talks to an external 24-bit delta-sigma ADC over a read-only SPI link, triggered by the ADC's active-low data-ready pin.
- Averages 2^AVG_LOG2 conversions, then presents a stable unsigned 24-bit adc_value, updated only on a one-cycle adc_valid strobe.
- Flags a missing-converter condition with a sticky timeout bit.

Parameters:
- CLK_DIV, 50: system clocks per SCLK half-period (1 MHz SCLK at 100 MHz); minimum 4.
- AVG_LOG2, 3: log2 of samples averaged per output (8); legal range 0..6.
- DRDY_TIMEOUT, 10000000: clocks spent in IDLE without DRDY before timeout (100 ms).

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- adc_drdy_n  in  1  ADC data-ready, active low, asynchronous.
- adc_miso  in  1  ADC serial data out, asynchronous.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  SPI clock, mode 0 (idle low).
- adc_value  out  24  averaged conversion, unsigned, held between updates.
- adc_valid  out  1  one-cycle pulse when adc_value updates.
- adc_timeout  out  1  sticky: no DRDY for DRDY_TIMEOUT clocks.

Behaviour:
- One clock (CLK100MHZ). Reset is synchronous and active-high. All outputs are registered.
- Reset values: adc_cs_n=1, adc_sclk=0, adc_value=0, adc_valid=0, adc_timeout=0. Accumulator, sample count, bit count and timeout counter are 0. State is IDLE with armed=1.
- Input synchronisation: adc_drdy_n and adc_miso each pass through a 2-flop synchroniser. All decisions use the synchronised versions.
- State machine: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> ACCUM -> IDLE.
- IDLE:
  - If synchronised drdy_n=1, set armed=1.
  - If drdy_n=0 and armed=1, clear armed and go to CS_SETUP.
  - The armed flag prevents a second read of the same conversion while DRDY is still low.
- CS_SETUP: adc_cs_n=0 for CLK_DIV clocks, SCLK low.
- SHIFT: 24 SCLK periods.
  - SCLK rises after each low half and falls after each high half.
  - MISO is sampled on the last clock of each SCLK high half, MSB first, into a 24-bit shift register.
  - The bit counter ends at 24. SCLK is low on exit.
- CS_HOLD: keep CS low for CLK_DIV clocks, then set adc_cs_n=1.
- ACCUM (1 clock):
  - acc += sample. acc is 24+AVG_LOG2 bits wide and never overflows.
  - cnt increments.
  - If cnt reaches 2^AVG_LOG2: adc_value <= acc_total >> AVG_LOG2 (truncate, no rounding), adc_valid=1 on the next clock for exactly one clock, adc_timeout<=0, acc and cnt cleared.
- Timing: one sample takes 2*CLK_DIV*(24+1)+~5 clocks (~2505 at defaults). adc_valid follows the ACCUM of the final sample by 1 clock.
- Timeout:
  - The counter runs only in IDLE and clears on leaving IDLE.
  - On reaching DRDY_TIMEOUT: adc_timeout<=1, counter restarts.
  - adc_value is not altered.
  - adc_timeout stays set until the next adc_valid.
- DRDY changes during CS_SETUP/SHIFT/CS_HOLD are ignored. The transfer always completes.
- Reset mid-transfer: the next clock gives adc_cs_n=1 and adc_sclk=0. The partial sample and partial accumulation are discarded, and no adc_valid is issued.
- AVG_LOG2=0: every sample produces an adc_valid.

Decomposition:
- Package adc_pkg:
  - ADC_BITS=24.
  - State enum {IDLE, CS_SETUP, SHIFT, CS_HOLD, ACCUM}.
  - SPI mode constant.
- One sub-module, adc_spi_shift:
  - Generates SCLK from CLK_DIV, runs the CS setup/hold timing and the 24-bit shift.
  - Interface: start pulse in; done pulse and data[23:0] out.
- The top level keeps sync, arming, averaging and timeout.

Test Plan:
- ADC model returns 0x3A2F80 on eight DRDY pulses -> exactly one adc_valid, adc_value=0x3A2F80; 192 rising SCLK edges; CS high between frames.
- Four samples of 3000000 and four of 3000007 -> adc_value=3000003 (truncated from 3000003.5).
- Eight samples of 0xFFFFFF -> adc_value=0xFFFFFF, no wrap; then eight of 0x000000 -> adc_value=0.
- DRDY held low for 20000 clocks after one conversion -> only one frame is read until DRDY returns high.
- DRDY held high for 10000000 clocks -> adc_timeout=1 and adc_value unchanged; eight further samples -> adc_timeout=0 on the adc_valid clock.
- reset asserted during SHIFT at bit 12 -> adc_cs_n=1 and adc_sclk=0 on the next clock, no adc_valid; the following eight samples of 0x123456 give adc_value=0x123456.
